// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (fetch and data), the arbiter and a shared
// single-port memory. The arbiter uses the slave view; the environment uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory: one access in flight,
// alternating priority under contention, per-access timeout with a sticky error flag.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_reg;
  logic [7:0]        wait_cnt_reg;
  logic              last_dm_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] dm_rdata_reg;
  logic              if_ready_reg;
  logic              dm_ready_reg;
  logic              err_reg;
  logic [7:0]        wait_cnt_inc;
  logic              dm_wins;

  assign wait_cnt_inc = wait_cnt_reg + 8'd1;
  // Data side wins a tie unless it took the previous grant.
  assign dm_wins = bus.dm_req && (!bus.if_req || !last_dm_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 8'd0;
      last_dm_reg   <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_ready_reg  <= 1'b0;
      dm_ready_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if_ready_reg <= 1'b0;
      dm_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (dm_wins) begin
            state_reg     <= DM_ACC;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= bus.dm_we;
            mem_addr_reg  <= bus.dm_addr;
            mem_wdata_reg <= bus.dm_wdata;
            last_dm_reg   <= 1'b1;
            wait_cnt_reg  <= 8'd0;
          end else if (bus.if_req) begin
            state_reg     <= IF_ACC;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= bus.if_addr;
            mem_wdata_reg <= '0;
            last_dm_reg   <= 1'b0;
            wait_cnt_reg  <= 8'd0;
          end
        end
        IF_ACC, DM_ACC: begin
          if (bus.mem_ack || wait_cnt_inc == TIMEOUT_C) begin
            // A late ack on the final allowed cycle still counts as a completion.
            state_reg   <= RESP;
            mem_req_reg <= 1'b0;
            if (!bus.mem_ack) begin
              err_reg <= 1'b1;
            end
            if (state_reg == IF_ACC) begin
              if_ready_reg <= 1'b1;
              if_rdata_reg <= bus.mem_ack ? bus.mem_rdata : '0;
            end else begin
              dm_ready_reg <= 1'b1;
              if (!mem_we_reg) begin
                dm_rdata_reg <= bus.mem_ack ? bus.mem_rdata : '0;
              end
            end
          end
          wait_cnt_reg <= bus.mem_ack ? wait_cnt_reg : wait_cnt_inc;
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.if_ready  = if_ready_reg;
  assign bus.dm_ready  = dm_ready_reg;
  assign bus.err       = err_reg;
  assign bus.stall     = (bus.if_req & ~if_ready_reg) | (bus.dm_req & ~dm_ready_reg);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench: two requesters and a memory with random ack latency, checked
// every cycle against a latency-arithmetic model of grants, responses and errors.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_mem_req"},   64'(bus.mem_req),   64'd0);
    check_val({pfx, "_mem_we"},    64'(bus.mem_we),    64'd0);
    check_val({pfx, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    check_val({pfx, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check_val({pfx, "_if_rdata"},  64'(bus.if_rdata),  64'd0);
    check_val({pfx, "_dm_rdata"},  64'(bus.dm_rdata),  64'd0);
    check_val({pfx, "_if_ready"},  64'(bus.if_ready),  64'd0);
    check_val({pfx, "_dm_ready"},  64'(bus.dm_ready),  64'd0);
    check_val({pfx, "_err"},       64'(bus.err),       64'd0);
  endtask

  // requester state
  bit          if_act, dm_act, dm_w;
  logic [31:0] if_a, dm_a, dm_wd;
  // model of the current/last access
  bit          has_acc, win_dm, last_dm_m, err_m, timed_out, rst_done;
  bit          acc, resp, e_if_rdy, e_dm_rdy, x_we;
  int          g, lat, n_acc, idle_cyc;
  logic [31:0] word, x_addr, x_wdata, if_rd_m, dm_rd_m;

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    if_act = 0; dm_act = 0; dm_w = 0; if_a = '0; dm_a = '0; dm_wd = '0;
    has_acc = 0; win_dm = 0; last_dm_m = 0; err_m = 0; timed_out = 0; rst_done = 0;
    g = 0; lat = 1; n_acc = 1; idle_cyc = 0; word = '0; x_addr = '0; x_we = 0;
    x_wdata = '0; if_rd_m = '0; dm_rd_m = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("init");
    rst = 1'b0;

    for (int t = 0; t < 1500; t++) begin
      if (t > 0) @(negedge clk);
      rst = 1'b0;
      acc      = has_acc && t >= g + 1 && t <= g + n_acc;
      resp     = has_acc && t == g + n_acc + 1;
      e_if_rdy = 0;
      e_dm_rdy = 0;
      if (resp) begin
        if (win_dm) begin
          e_dm_rdy = 1;
          if (!x_we) dm_rd_m = timed_out ? 32'd0 : word;
        end else begin
          e_if_rdy = 1;
          if_rd_m = timed_out ? 32'd0 : word;
        end
        if (timed_out) err_m = 1;
      end

      check_val("mem_req", 64'(bus.mem_req), 64'(acc));
      if (acc) begin
        check_val("mem_addr", 64'(bus.mem_addr), 64'(x_addr));
        check_val("mem_we", 64'(bus.mem_we), 64'(x_we));
        if (x_we) check_val("mem_wdata", 64'(bus.mem_wdata), 64'(x_wdata));
      end
      check_val("if_ready", 64'(bus.if_ready), 64'(e_if_rdy));
      check_val("dm_ready", 64'(bus.dm_ready), 64'(e_dm_rdy));
      check_val("if_rdata", 64'(bus.if_rdata), 64'(if_rd_m));
      check_val("dm_rdata", 64'(bus.dm_rdata), 64'(dm_rd_m));
      check_val("err", 64'(bus.err), 64'(err_m));

      // Abandon the first DM access on its second memory cycle.
      if (!rst_done && acc && win_dm && t == g + 2) begin
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        rst_done = 1; has_acc = 0; idle_cyc = t + 1;
        last_dm_m = 0; err_m = 0; if_rd_m = '0; dm_rd_m = '0;
        continue;
      end

      if (resp && !win_dm) if_act = 0;
      if (resp && win_dm) dm_act = 0;
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_a = $urandom;
      end
      if (!dm_act && $urandom_range(0, 2) == 0) begin
        dm_act = 1; dm_a = $urandom; dm_w = 1'($urandom); dm_wd = $urandom;
      end
      bus.if_req   = if_act;
      bus.if_addr  = if_act ? if_a : $urandom;
      bus.dm_req   = dm_act;
      bus.dm_we    = dm_act ? dm_w : 1'($urandom);
      bus.dm_addr  = dm_act ? dm_a : $urandom;
      bus.dm_wdata = dm_act ? dm_wd : $urandom;

      if (t >= idle_cyc) begin
        if (if_act || dm_act) begin
          win_dm    = dm_act && (!if_act || !last_dm_m);
          last_dm_m = win_dm;
          g         = t;
          has_acc   = 1;
          lat       = (!rst_done && win_dm) ? $urandom_range(3, 5) : $urandom_range(1, 5);
          n_acc     = (lat <= TO) ? lat : TO;
          timed_out = lat > TO;
          word      = $urandom;
          x_addr    = win_dm ? dm_a : if_a;
          x_we      = win_dm && dm_w;
          x_wdata   = dm_wd;
          idle_cyc  = t + n_acc + 2;
        end else begin
          idle_cyc = t + 1;
        end
      end

      if (acc && t == g + lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = word;
      end else begin
        bus.mem_ack   = !acc && ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end

      #1;
      check_val("stall", 64'(bus.stall), 64'((if_act & ~e_if_rdy) | (dm_act & ~e_dm_rdy)));
    end

    check_val("midrst_done", 64'(rst_done), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
